// File: rtl/hack_control_unit.sv
// hack_control_unit: multi-cycle Hack CPU control/register stage feeding a combinational ALU
// Optional halt detection (output halted, HALT state) is enabled by defining HACK_HALT_DETECT_EN.
module hack_control_unit #(
   parameter int ADDR_W = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [15:0]       rom_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       alu_x,
   output logic [15:0]       alu_y,
   output logic              alu_zx,
   output logic              alu_nx,
   output logic              alu_zy,
   output logic              alu_ny,
   output logic              alu_f,
   output logic              alu_no,
   input  logic [15:0]       alu_out,
   input  logic              alu_zr,
   input  logic              alu_ng,
`ifdef HACK_HALT_DETECT_EN
   output logic              halted,
`endif
   output logic [ADDR_W-1:0] pc
);
   typedef enum logic [2:0] {
      FETCH, DECODE, MEMRD, EXEC, MEMWR
`ifdef HACK_HALT_DETECT_EN
      , HALT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       a_q, a_d, d_q, d_d, ir_q, ir_d, mreg_q, mreg_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] pc_q, pc_d, waddr_q, waddr_d;
   logic              rom_req_q, rom_req_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic              taken;
`ifdef HACK_HALT_DETECT_EN
   logic              halt_q, halt_d;
   assign halted = halt_q;
`endif

   assign taken     = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
   assign rom_req   = rom_req_q;
   assign rom_addr  = pc_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = (state_q == MEMWR) ? waddr_q : a_q[ADDR_W-1:0];
   assign mem_wdata = wdata_q;
   assign alu_x     = d_q;
   assign alu_y     = ir_q[12] ? mreg_q : a_q;
   assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[11:6];
   assign pc        = pc_q;

   // Next-state and register-update logic; request flops decode the next state so they are glitch-free
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      ir_d    = ir_q;
      mreg_d  = mreg_q;
      pc_d    = pc_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
`ifdef HACK_HALT_DETECT_EN
      halt_d  = halt_q;
`endif
      case (state_q)
         FETCH: if (rom_req_q && rom_ack) begin
            ir_d    = rom_data;
            state_d = DECODE;
         end
         DECODE: if (!ir_q[15]) begin
            a_d     = ir_q;
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
         end else state_d = ir_q[12] ? MEMRD : EXEC;
         MEMRD: if (mem_ack) begin
            mreg_d  = mem_rdata;
            state_d = EXEC;
         end
         EXEC: begin
            if (ir_q[5]) a_d = alu_out;
            if (ir_q[4]) d_d = alu_out;
            pc_d    = taken ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
            wdata_d = alu_out;
            waddr_d = a_q[ADDR_W-1:0];
            state_d = ir_q[3] ? MEMWR : FETCH;
`ifdef HACK_HALT_DETECT_EN
            if (taken && a_q[ADDR_W-1:0] == pc_q) begin
               halt_d  = 1'b1;
               state_d = HALT;
            end
`endif
         end
         MEMWR: if (mem_ack) state_d = FETCH;
         default: ;
      endcase
      rom_req_d = state_d == FETCH;
      mem_req_d = state_d == MEMRD || state_d == MEMWR;
      mem_we_d  = state_d == MEMWR;
   end

   // State and register flops; reset abandons any outstanding request immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         a_q       <= '0;
         d_q       <= '0;
         ir_q      <= '0;
         mreg_q    <= '0;
         pc_q      <= RESET_PC;
         waddr_q   <= '0;
         wdata_q   <= '0;
         rom_req_q <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
         halt_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         d_q       <= d_d;
         ir_q      <= ir_d;
         mreg_q    <= mreg_d;
         pc_q      <= pc_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         rom_req_q <= rom_req_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
`ifdef HACK_HALT_DETECT_EN
         halt_q    <= halt_d;
`endif
      end
   end
endmodule

// File: tb/tb_hack_control_unit.sv
// tb_hack_control_unit: directed program tests for hack_control_unit with ROM, RAM and ALU models
module tb_hack_control_unit;
   logic        clk = 0, rst_n = 0;
   logic        rom_req, rom_ack = 0, mem_req, mem_we, mem_ack = 0;
   logic [14:0] rom_addr, mem_addr, pc;
   logic [15:0] rom_data = 0, mem_wdata, mem_rdata = 0, alu_x, alu_y, alu_out;
   logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
`ifdef HACK_HALT_DETECT_EN
   logic        halted;
`endif
   logic [15:0] rom [64];
   logic [15:0] dmem [256];
   int          mem_wait = 0, rom_cnt = 0, mem_cnt = 0;
   int          rd_cnt = 0, wr_cnt = 0;
   logic [14:0] rd_addr = 0, wr_addr = 0;
   logic [15:0] wr_data = 0;
   bit          mem_auto = 1;
   int          n_tests = 0, n_fail = 0;

   hack_control_unit dut (
      .clk(clk), .rst_n(rst_n),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .alu_x(alu_x), .alu_y(alu_y),
      .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
`ifdef HACK_HALT_DETECT_EN
      .halted(halted),
`endif
      .pc(pc)
   );

   always #5 clk = ~clk;

   // Reference Hack ALU
   always_comb begin
      logic [15:0] x1, y1, o;
      x1 = alu_zx ? 16'h0 : alu_x;
      x1 = alu_nx ? ~x1 : x1;
      y1 = alu_zy ? 16'h0 : alu_y;
      y1 = alu_ny ? ~y1 : y1;
      o = alu_f ? x1 + y1 : x1 & y1;
      o = alu_no ? ~o : o;
      alu_out = o;
      alu_zr = o == 16'h0;
      alu_ng = o[15];
   end

   // Zero-wait ROM responder
   initial forever begin
      @(negedge clk);
      if (rom_req && rom_cnt == 0) begin
         rom_ack = 1;
         rom_data = rom[rom_addr[5:0]];
         rom_cnt = 1;
      end else begin
         rom_ack = 0;
         if (!rom_req) rom_cnt = 0;
      end
   end

   // RAM responder: ack after mem_wait idle cycles, logs every completed access
   initial forever begin
      @(negedge clk);
      if (mem_auto) begin
         if (mem_req && mem_cnt == mem_wait) begin
            mem_ack = 1;
            if (mem_we) begin
               dmem[mem_addr[7:0]] = mem_wdata;
               wr_cnt++;
               wr_addr = mem_addr;
               wr_data = mem_wdata;
            end else begin
               mem_rdata = dmem[mem_addr[7:0]];
               rd_cnt++;
               rd_addr = mem_addr;
            end
            mem_cnt = -1;
         end else begin
            mem_ack = 0;
            mem_cnt = mem_req ? mem_cnt + 1 : 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 16'h0;
   endtask

   // Asserts reset between edges, checks idle outputs, releases, and returns at FETCH entry
   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      #2;
      check("rst_rom_req", rom_req, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_pc", pc, 0);
      rd_cnt = 0;
      wr_cnt = 0;
      @(negedge clk);
      rst_n = 1;
      step(1);
      check("fetch_start", rom_req, 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
      // A-instruction @7
      clear_rom();
      rom[0] = 16'h0007;
      do_reset();
      step(2);
      check("ainst_pc", pc, 1);
      check("ainst_a", mem_addr, 7);
      check("ainst_nomem", mem_req, 0);
      // @3; D=A; @4; D=D+A
      clear_rom();
      rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'h0004; rom[3] = 16'hE090;
      do_reset();
      step(9);
      check("add_pc_early", pc, 3);
      step(1);
      check("add_d", alu_x, 7);
      check("add_pc", pc, 4);
      check("add_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 6'b000010);
      // @100; D=M+1 with the read acked in the second MEMRD cycle
      clear_rom();
      rom[0] = 16'h0064; rom[1] = 16'hFDD0;
      dmem[100] = 16'h0005;
      mem_wait = 1;
      do_reset();
      step(6);
      check("mrd_pc_early", pc, 1);
      step(1);
      check("mrd_pc", pc, 2);
      check("mrd_d", alu_x, 6);
      check("mrd_count", rd_cnt, 1);
      check("mrd_addr", rd_addr, 100);
      mem_wait = 0;
      // @9; D=A; @200; AM=D
      clear_rom();
      rom[0] = 16'h0009; rom[1] = 16'hEC10; rom[2] = 16'h00C8; rom[3] = 16'hE328;
      do_reset();
      step(10);
      check("mwr_req", {mem_req, mem_we}, 2'b11);
      check("mwr_addr_out", mem_addr, 200);
      check("mwr_data_out", mem_wdata, 9);
      step(1);
      check("mwr_count", wr_cnt, 1);
      check("mwr_addr", wr_addr, 200);
      check("mwr_data", wr_data, 9);
      check("mwr_a", mem_addr, 9);
      check("mwr_pc", pc, 4);
      check("mwr_idle", mem_req, 0);
      // D=-1; @50; D;JLT -> taken
      clear_rom();
      rom[0] = 16'hEE90; rom[1] = 16'h0032; rom[2] = 16'hE304;
      do_reset();
      step(8);
      check("jlt_taken_pc", pc, 50);
      // D=0; @50; D;JLT -> not taken
      rom[0] = 16'hEA90;
      do_reset();
      step(8);
      check("jlt_not_pc", pc, 3);
      // D=0; @50; D;JEQ -> taken
      rom[2] = 16'hE302;
      do_reset();
      step(8);
      check("jeq_taken_pc", pc, 50);
      // Reset during a stalled write, then a stray ack
      clear_rom();
      rom[0] = 16'h00C8; rom[1] = 16'hE308;
      mem_auto = 0;
      mem_ack = 0;
      do_reset();
      step(5);
      check("stall_req", {mem_req, mem_we}, 2'b11);
      #2;
      rst_n = 0;
      #1;
      check("async_mem_req", mem_req, 0);
      check("async_pc", pc, 0);
      @(negedge clk);
      rst_n = 1;
      mem_ack = 1;
      step(1);
      check("stray_req", mem_req, 0);
      step(1);
      check("stray_req2", mem_req, 0);
      check("stray_pc", pc, 0);
      mem_ack = 0;
      mem_auto = 1;
`ifdef HACK_HALT_DETECT_EN
      // @5; 0;JMP at 1, self-loop 0;JMP at 5
      clear_rom();
      rom[0] = 16'h0005; rom[1] = 16'hEA87; rom[5] = 16'hEA87;
      do_reset();
      step(5);
      check("halt_pre_pc", pc, 5);
      check("halt_pre", halted, 0);
      step(3);
      check("halt_set", halted, 1);
      check("halt_rom_req", rom_req, 0);
      step(3);
      check("halt_hold", halted, 1);
      check("halt_park", {rom_req, mem_req}, 2'b00);
      check("halt_pc", pc, 5);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
